// File: rtl/mem_loader.sv
// mem_loader: accepts a header plus instruction/data image on a valid/ready stream, writes it into two word RAMs, then releases the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing mod-2^32 checksum word (CHECK state) before DONE.
module mem_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err
);
    // Counts reach 2^ADDR_W, so they need one bit more than an address.
    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [31:0] MAX_CNT = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        INSTR,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t TERM            = CHECK;
    localparam logic   LAST_ON_PAYLOAD = 1'b0;
`else
    localparam state_t TERM            = DONE;
    localparam logic   LAST_ON_PAYLOAD = 1'b1;
`endif

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] n_i;
    logic [CNT_W-1:0] n_d;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] n_i_next;
    logic [CNT_W-1:0] n_d_next;
    logic [CNT_W-1:0] idx_next;
    logic [CNT_W-1:0] idx_inc;
    logic [15:0]      hdr_ni;
    logic [15:0]      hdr_nd;
    logic             accept;
    logic             hdr_bad;
    logic             hdr_empty;
    logic             last_i;
    logic             last_d;
    logic             exp_last;
    logic             wr_en;
    logic             wr_sel;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    assign accept    = s_valid && s_ready;
    assign hdr_ni    = s_data[31:16];
    assign hdr_nd    = s_data[15:0];
    assign hdr_bad   = ({16'd0, hdr_ni} > MAX_CNT) || ({16'd0, hdr_nd} > MAX_CNT);
    assign hdr_empty = (hdr_ni == 16'd0) && (hdr_nd == 16'd0);
    assign idx_inc   = idx + CNT_W'(1);
    assign last_i    = (idx_inc == n_i);
    assign last_d    = (idx_inc == n_d);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        n_i_next   = n_i;
        n_d_next   = n_d;
        idx_next   = idx;
        exp_last   = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (load_req) begin
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (accept) begin
                    n_i_next = CNT_W'(hdr_ni);
                    n_d_next = CNT_W'(hdr_nd);
                    idx_next = '0;
                    exp_last = hdr_empty && LAST_ON_PAYLOAD;
                    if (hdr_bad || (s_last != exp_last)) begin
                        state_next = ERR;
                    end else if (hdr_ni != 16'd0) begin
                        state_next = INSTR;
                    end else if (hdr_nd != 16'd0) begin
                        state_next = DATA;
                    end else begin
                        state_next = TERM;
                    end
                end
            end
            INSTR: begin
                if (accept) begin
                    exp_last = last_i && (n_d == '0) && LAST_ON_PAYLOAD;
                    if (s_last != exp_last) begin
                        state_next = ERR;
                    end else begin
                        wr_en    = 1'b1;
                        idx_next = idx_inc;
                        if (last_i) begin
                            idx_next   = '0;
                            state_next = (n_d != '0) ? DATA : TERM;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    exp_last = last_d && LAST_ON_PAYLOAD;
                    if (s_last != exp_last) begin
                        state_next = ERR;
                    end else begin
                        wr_en    = 1'b1;
                        wr_sel   = 1'b1;
                        idx_next = idx_inc;
                        if (last_d) begin
                            idx_next   = '0;
                            state_next = TERM;
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_next = (s_last && (s_data == sum)) ? DONE : ERR;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Write port is registered: the strobe appears the cycle after the accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_i       <= '0;
            n_d       <= '0;
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            n_i    <= n_i_next;
            n_d    <= n_d_next;
            idx    <= idx_next;
            mem_we <= wr_en;
            if (wr_en) begin
                mem_sel   <= wr_sel;
                mem_addr  <= idx[ADDR_W-1:0];
                mem_wdata <= s_data;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if ((state == HEADER) && accept) begin
            sum <= '0;
        end else if (wr_en) begin
            sum <= sum + s_data;
        end
    end
`endif

    always_comb begin
        busy = 1'b0;
        case (state)
            HEADER, INSTR, DATA: busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK:               busy = 1'b1;
`endif
            default:             busy = 1'b0;
        endcase
    end

    assign s_ready   = busy;
    assign done      = (state == DONE);
    assign cpu_start = (state == DONE);
    assign err       = (state == ERR);

endmodule
